rr_grant_scheduler: RTL and testbench
=====================================

Name: rr_grant_scheduler

Overview:
- Round-robin scheduler sharing one 16-way resource among 16 requesters; the granted requester is driven as a one-hot select (1 << index), the same 4-to-16 decode used across the dataflow blocks.
- Grants are registered and held until the owner releases. Arbitration is fair: the last winner gets lowest priority next round.
- Sits between the requester bank and the decoded select bus of the shared datapath.

Parameters:
- N_REQ, 16, number of requesters; fixed at 16 for this revision.
- IDX_W, 4, width of the grant index; clog2(N_REQ).
- HOLD_MAX, 15, maximum cycles a grant may be held; used only with ARB_TIMEOUT_EN; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- req  input  16  request vector; bit i is requester i.
- done  input  1  owner release pulse; sampled only in GRANT.
- grant  output  16  registered one-hot grant, equal to 16'b1 << grant_idx while grant_valid=1, else 0.
- grant_idx  output  4  index of the current owner.
- grant_valid  output  1  a grant is active.
- timeout  output  1  one-cycle forced-release pulse; present only with ARB_TIMEOUT_EN.

Behaviour:
- Reset (async, any time, including mid-grant):
  - grant=0, grant_idx=0, grant_valid=0, timeout=0, state=IDLE.
  - Last-winner pointer ptr=15, so requester 0 has top priority first.
- States: IDLE, GRANT.
- IDLE:
  - If req != 0, select the first set bit scanning ptr+1, ptr+2, ... wrapping modulo 16.
  - On the next edge: grant_idx=winner, grant=1<<winner, grant_valid=1, state=GRANT.
  - Latency is 1 cycle from req sampled to grant visible.
  - If req == 0, stay in IDLE with outputs 0.
  - done is ignored in IDLE.
- GRANT:
  - Hold grant, grant_idx and grant_valid; req changes on other bits have no effect.
- Release condition, any one of:
  - done=1;
  - req[grant_idx]=0 (requester withdrew);
  - timeout, when the feature is compiled in.
- On release, at the next edge:
  - grant=0, grant_valid=0, ptr=grant_idx, state=IDLE.
  - grant_idx keeps its last value.
- Re-arbitration: minimum one idle cycle between consecutive grants. Back-to-back ownership by different requesters is separated by exactly 1 cycle of grant_valid=0 when requests are pending.
- Simultaneous release causes (done, req drop, timeout) produce a single release.
- Wrap-around: if ptr=15, the scan starts at 0. If the only requester is the previous winner, it wins again after the idle cycle.
- Invariant: grant has at most one bit set; grant==0 exactly when grant_valid==0.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With the macro:
  - An 8-bit hold counter clears on grant entry and increments each GRANT cycle.
  - When the count reaches HOLD_MAX-1 with no other release, a forced release occurs and timeout pulses high for 1 cycle, aligned with grant deasserting.
  - The counter and timeout reset to 0.
- Without the macro: no counter and no timeout port; grant is held indefinitely until done or the request drops.

Decomposition:
- Package rr_sched_pkg:
  - N_REQ, IDX_W;
  - state enum {IDLE, GRANT};
  - function rotate-priority-find returning the winner index.
- Sub-module arb_onehot_dec: index-to-one-hot decode (16'b1 << idx). It is instantiated for the grant output and reused by other select-bus users.

Test Plan:
- Reset then req=16'h0001 → after 1 cycle grant=16'h0001, grant_idx=0, grant_valid=1. Assert rst mid-grant → all outputs 0 immediately, without waiting for clk.
- req=16'h8001 held, done pulsed each grant → grants alternate idx 0, 15, 0, 15 with one idle cycle between.
- req=16'hFFFF with done every grant → idx sequence 0,1,2,...,15,0 (wrap), every grant exactly one-hot.
- Grant to idx 3 with req=16'h0018, drop req[3] → release next edge; idx 4 granted after one idle cycle. Other req toggles during the grant do not change grant.
- done asserted in IDLE with req=0 → no change. done and req[idx] drop in the same cycle → a single release, ptr=idx.
- ARB_TIMEOUT_EN, HOLD_MAX=4, req=16'h0004, no done → grant held 4 cycles, then timeout=1 for 1 cycle with grant=0. Idx 2 is re-granted after the idle cycle.

Source files
------------

// File: rtl/rr_sched_pkg.sv
// Shared constants, FSM state type and rotating-priority search for the
// round-robin grant scheduler and its select-bus decoder.
package rr_sched_pkg;

  localparam int N_REQ = 16;
  localparam int IDX_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // First set bit of req scanning ptr+1, ptr+2, ... modulo N_REQ; ptr itself is last.
  function automatic logic [IDX_W-1:0] rr_find(input logic [N_REQ-1:0] req,
                                                input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] win;
    logic             found;
    win   = '0;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = ptr + IDX_W'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/arb_onehot_dec.sv
// Index-to-one-hot decode (1 << idx) shared by the select-bus users.
module arb_onehot_dec
  import rr_sched_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output logic [N_REQ-1:0] onehot
);

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_dec
      assign onehot[gi] = (idx == IDX_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/rr_grant_scheduler.sv
// Round-robin grant scheduler: 16 requesters, registered one-hot grant held
// until release. Build macro ARB_TIMEOUT_EN adds a forced-release hold limit.
module rr_grant_scheduler
  import rr_sched_pkg::*;
`ifdef ARB_TIMEOUT_EN
#(
  parameter int HOLD_MAX = 15
)
`endif
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
`ifdef ARB_TIMEOUT_EN
  ,
  output logic             timeout
`endif
);

  state_t           state_reg;
  logic [IDX_W-1:0] ptr_reg;
  logic [IDX_W-1:0] grant_idx_reg;
  logic             grant_valid_reg;
  logic [N_REQ-1:0] grant_reg;

  logic [IDX_W-1:0] winner;
  logic [N_REQ-1:0] winner_onehot;
  logic             user_release;
  logic             hold_expired;
  logic             release_now;

  assign winner       = rr_find(req, ptr_reg);
  assign user_release = done | ~req[grant_idx_reg];
  assign release_now  = user_release | hold_expired;

  arb_onehot_dec u_dec (
    .idx    (winner),
    .onehot (winner_onehot)
  );

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  logic [7:0] hold_cnt_reg;
  logic       timeout_reg;

  assign hold_expired = (state_reg == GRANT) && (hold_cnt_reg == HOLD_LAST);
  assign timeout      = timeout_reg;

  // Counter is parked at zero while idle so it starts from 0 on grant entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      timeout_reg <= 1'b0;
      if (state_reg == IDLE) begin
        hold_cnt_reg <= '0;
      end else if (!release_now) begin
        hold_cnt_reg <= hold_cnt_reg + 8'd1;
      end
      if (hold_expired && !user_release) begin
        timeout_reg <= 1'b1;
      end
    end
  end
`else
  assign hold_expired = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      ptr_reg         <= IDX_W'(N_REQ - 1);
      grant_idx_reg   <= '0;
      grant_valid_reg <= 1'b0;
      grant_reg       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|req) begin
            grant_idx_reg   <= winner;
            grant_reg       <= winner_onehot;
            grant_valid_reg <= 1'b1;
            state_reg       <= GRANT;
          end
        end
        GRANT: begin
          // grant_idx is left at the last owner after release.
          if (release_now) begin
            grant_reg       <= '0;
            grant_valid_reg <= 1'b0;
            ptr_reg         <= grant_idx_reg;
            state_reg       <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign grant       = grant_reg;
  assign grant_idx   = grant_idx_reg;
  assign grant_valid = grant_valid_reg;

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Self-checking bench for rr_grant_scheduler with a behavioural round-robin model.
module tb_rr_grant_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req;
  logic        done;
  logic [15:0] grant;
  logic [3:0]  grant_idx;
  logic        grant_valid;

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD  = 4;
  localparam bit TO_EN = 1'b1;
  logic timeout;
  rr_grant_scheduler #(.HOLD_MAX(HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done), .grant(grant),
    .grant_idx(grant_idx), .grant_valid(grant_valid), .timeout(timeout)
  );
`else
  localparam int HOLD  = 0;
  localparam bit TO_EN = 1'b0;
  rr_grant_scheduler dut (
    .clk(clk), .rst(rst), .req(req), .done(done), .grant(grant),
    .grant_idx(grant_idx), .grant_valid(grant_valid)
  );
`endif

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Model: current owner (if any), last winner, cycles held, timeout pulse.
  bit          m_valid;
  bit          m_to;
  int          m_idx;
  int          m_ptr;
  int          m_cnt;
  logic [15:0] exp_grant;

  task automatic model_reset();
    m_valid   = 1'b0;
    m_to      = 1'b0;
    m_idx     = 0;
    m_ptr     = 15;
    m_cnt     = 0;
    exp_grant = 16'h0000;
  endtask

  task automatic model_step(input logic [15:0] r, input logic d);
    bit rel_user;
    bit rel_to;
    int c;
    if (!m_valid) begin
      m_to = 1'b0;
      for (int k = 1; k <= 16; k++) begin
        c = (m_ptr + k) % 16;
        if (r[c] && !m_valid) begin
          m_idx   = c;
          m_valid = 1'b1;
          m_cnt   = 0;
        end
      end
    end else begin
      rel_user = d || !r[m_idx];
      rel_to   = TO_EN && (m_cnt == HOLD - 1);
      if (rel_user || rel_to) begin
        m_valid = 1'b0;
        m_ptr   = m_idx;
        m_to    = rel_to && !rel_user;
      end else begin
        m_cnt++;
        m_to = 1'b0;
      end
    end
    exp_grant = m_valid ? (16'h0001 << m_idx) : 16'h0000;
  endtask

  task automatic tick(input logic [15:0] r, input logic d);
    req  = r;
    done = d;
    @(posedge clk);
    model_step(r, d);
    cyc++;
    #1;
    $display("[TB] cyc=%0d req=%h done=%b -> grant=%h idx=%0d valid=%b", cyc, r, d, grant, grant_idx, grant_valid);
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = 16'h0000;
    done = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (grant !== 16'h0000 || grant_idx !== 4'd0 || grant_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: grant=%h idx=%0d valid=%b, expected 0000/0/0", grant, grant_idx, grant_valid);
    end
    tick(16'h0001, 1'b0);
    tests++;
    if (grant !== 16'h0001 || grant_idx !== 4'd0 || grant_valid !== 1'b1) begin
      fails++;
      $display("FAIL first_grant: grant=%h idx=%0d valid=%b, expected 0001/0/1", grant, grant_idx, grant_valid);
    end
    tick(16'h0001, 1'b0);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    tests++;
    if (grant !== 16'h0000 || grant_idx !== 4'd0 || grant_valid !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: grant=%h idx=%0d valid=%b, expected 0000/0/0", grant, grant_idx, grant_valid);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_alternate();
    int seen[$];
    int expv[4] = '{0, 15, 0, 15};
    bit prev_v;
    do_reset();
    prev_v = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(16'h8001, 1'b1);
      tests++;
      if (grant !== exp_grant || grant_idx !== 4'(m_idx) || grant_valid !== m_valid) begin
        fails++;
        $display("FAIL alternate: grant=%h idx=%0d valid=%b, expected %h/%0d/%b", grant, grant_idx, grant_valid, exp_grant, m_idx, m_valid);
      end
      if (grant_valid === 1'b1 && !prev_v) seen.push_back(int'(grant_idx));
      prev_v = (grant_valid === 1'b1);
    end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (i >= seen.size() || seen[i] != expv[i]) begin
        fails++;
        $display("FAIL alternate_seq[%0d]: got %0d, expected %0d", i, (i < seen.size()) ? seen[i] : -1, expv[i]);
      end
    end
  endtask

  task automatic test_wrap_all();
    int  n_grants;
    bit  prev_v;
    do_reset();
    n_grants = 0;
    prev_v   = 1'b0;
    for (int i = 0; i < 34; i++) begin
      tick(16'hFFFF, 1'b1);
      tests++;
      if (grant !== exp_grant || grant_idx !== 4'(m_idx) || grant_valid !== m_valid) begin
        fails++;
        $display("FAIL wrap_all: grant=%h idx=%0d valid=%b, expected %h/%0d/%b", grant, grant_idx, grant_valid, exp_grant, m_idx, m_valid);
      end
      if (grant_valid === 1'b1) begin
        tests++;
        if ($countones(grant) != 1) begin
          fails++;
          $display("FAIL wrap_onehot: grant=%h, expected exactly one bit", grant);
        end
        if (!prev_v) begin
          tests++;
          if (int'(grant_idx) != n_grants % 16) begin
            fails++;
            $display("FAIL wrap_seq: idx=%0d, expected %0d", grant_idx, n_grants % 16);
          end
          n_grants++;
        end
      end
      prev_v = (grant_valid === 1'b1);
    end
  endtask

  task automatic test_withdraw();
    logic [15:0] r;
    do_reset();
    tick(16'h0018, 1'b0);
    tests++;
    if (grant !== 16'h0008 || grant_idx !== 4'd3 || grant_valid !== 1'b1) begin
      fails++;
      $display("FAIL withdraw_grant3: grant=%h idx=%0d valid=%b, expected 0008/3/1", grant, grant_idx, grant_valid);
    end
    for (int i = 0; i < 5; i++) begin
      r = 16'($urandom) | 16'h0008;
      tick(r, 1'b0);
      tests++;
      if (grant !== 16'h0008 || grant_idx !== 4'd3 || grant_valid !== 1'b1) begin
        fails++;
        $display("FAIL withdraw_hold: grant=%h idx=%0d valid=%b, expected 0008/3/1", grant, grant_idx, grant_valid);
      end
    end
    tick(16'h0010, 1'b0);
    tests++;
    if (grant !== 16'h0000 || grant_idx !== 4'd3 || grant_valid !== 1'b0) begin
      fails++;
      $display("FAIL withdraw_release: grant=%h idx=%0d valid=%b, expected 0000/3/0", grant, grant_idx, grant_valid);
    end
    tick(16'h0010, 1'b0);
    tests++;
    if (grant !== 16'h0010 || grant_idx !== 4'd4 || grant_valid !== 1'b1) begin
      fails++;
      $display("FAIL withdraw_next: grant=%h idx=%0d valid=%b, expected 0010/4/1", grant, grant_idx, grant_valid);
    end
  endtask

  task automatic test_done_idle();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick(16'h0000, 1'b1);
      tests++;
      if (grant !== 16'h0000 || grant_idx !== 4'd0 || grant_valid !== 1'b0) begin
        fails++;
        $display("FAIL done_idle: grant=%h idx=%0d valid=%b, expected 0000/0/0", grant, grant_idx, grant_valid);
      end
    end
    tick(16'h0020, 1'b0);
    tick(16'h0000, 1'b1);
    tests++;
    if (grant !== 16'h0000 || grant_idx !== 4'd5 || grant_valid !== 1'b0) begin
      fails++;
      $display("FAIL dual_release: grant=%h idx=%0d valid=%b, expected 0000/5/0", grant, grant_idx, grant_valid);
    end
    tick(16'h0060, 1'b0);
    tests++;
    if (grant !== 16'h0040 || grant_idx !== 4'd6 || grant_valid !== 1'b1) begin
      fails++;
      $display("FAIL dual_release_ptr: grant=%h idx=%0d valid=%b, expected 0040/6/1", grant, grant_idx, grant_valid);
    end
  endtask

  task automatic test_random();
    logic [15:0] r;
    logic        d;
    do_reset();
    r = 16'h0000;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) != 0) r = 16'($urandom) & 16'($urandom);
      d = ($urandom_range(0, 3) == 0);
      tick(r, d);
      tests++;
      if (grant !== exp_grant || grant_idx !== 4'(m_idx) || grant_valid !== m_valid) begin
        fails++;
        $display("FAIL random: grant=%h idx=%0d valid=%b, expected %h/%0d/%b", grant, grant_idx, grant_valid, exp_grant, m_idx, m_valid);
      end
`ifdef ARB_TIMEOUT_EN
      tests++;
      if (timeout !== m_to) begin
        fails++;
        $display("FAIL random_timeout: timeout=%b, expected %b", timeout, m_to);
      end
`endif
    end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    int held;
    int pulses;
    do_reset();
    held   = 0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick(16'h0004, 1'b0);
      if (grant_valid === 1'b1) held++;
      if (timeout === 1'b1) begin
        pulses++;
        tests++;
        if (grant !== 16'h0000 || held != 4) begin
          fails++;
          $display("FAIL timeout_align: grant=%h held=%0d, expected 0000 after 4", grant, held);
        end
        held = 0;
      end
      tests++;
      if (grant !== exp_grant || grant_idx !== 4'd2 || grant_valid !== m_valid || timeout !== m_to) begin
        fails++;
        $display("FAIL timeout: grant=%h valid=%b to=%b, expected %h/%b/%b", grant, grant_valid, timeout, exp_grant, m_valid, m_to);
      end
    end
    tests++;
    if (pulses != 2) begin
      fails++;
      $display("FAIL timeout_count: pulses=%0d, expected 2", pulses);
    end
  endtask
`endif

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst  = 1'b1;
    req  = 16'h0000;
    done = 1'b0;
    model_reset();
    test_reset();
    test_alternate();
    test_wrap_all();
    test_withdraw();
    test_done_idle();
    test_random();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
